// File: rtl/ide_sd_sector_bridge.sv
// Multi-sector read bridge: IDE device front end <-> SD SPI controller.
// Takes a read command (first LBA + sector count), issues one SD sector read
// per sector with an incrementing LBA, packs SD bytes into 16-bit words in a
// FIFO and hands complete sectors to the IDE data register (DRQ/INTRQ).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command strobe / ready (=~busy)
//   cmd_lba, cmd_count           first LBA, sector count (0 = 2**CNT_W)
//   sd_start_read, sd_lba        one-cycle SD read request and its LBA
//   sd_data, sd_data_valid       SD byte stream
//   sd_done, sd_error            SD sector-complete / error pulses
//   host_rd, host_data           IDE data-register pop / FIFO head word
//   host_drq, intrq              sector ready for host / interrupt level
//   busy, err                    command in progress / error latch
//   status_leds                  {0.., err, intrq, host_drq, state[2:0]}
module ide_sd_sector_bridge #(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned FIFO_WORDS   = 512,
  parameter int unsigned LBA_W        = 32,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned TIMEOUT_CYC  = 27000000,
  parameter int unsigned LED_W        = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LBA_W-1:0] cmd_lba,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             sd_start_read,
  output logic [LBA_W-1:0] sd_lba,
  input  logic [7:0]       sd_data,
  input  logic             sd_data_valid,
  input  logic             sd_done,
  input  logic             sd_error,
  input  logic             host_rd,
  output logic [15:0]      host_data,
  output logic             host_drq,
  output logic             intrq,
  output logic             busy,
  output logic             err,
  output logic [LED_W-1:0] status_leds
);

  localparam int unsigned SECTOR_WORDS = SECTOR_BYTES / 2;
  localparam int unsigned AW    = (FIFO_WORDS > 1) ? $clog2(FIFO_WORDS) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned BC_W  = $clog2(SECTOR_BYTES + 2);
  localparam int unsigned PC_W  = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
  localparam int unsigned REM_W = CNT_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SPACE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [LBA_W-1:0] lba_nxt;
  logic [REM_W-1:0] remaining, rem_nxt;
  logic             busy_nxt, err_nxt, intrq_nxt, drq_nxt, start_nxt;
  logic [BC_W-1:0]  byte_cnt, byte_nxt;
  logic [7:0]       lo_byte, lo_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic [AW-1:0]    wr_ptr, wr_nxt, rd_ptr, rd_nxt;
  logic [CW-1:0]    fifo_cnt, cnt_nxt, sectors_ready, sec_nxt;
  logic [PC_W-1:0]  pop_cnt, pop_cnt_nxt;
  logic             push, pop, flush, go_err, sec_done, sec_popped;
  logic             intrq_set, intrq_clr, mem_we;
  logic [15:0]      fifo_mem [0:FIFO_WORDS-1];

  // Next-state, datapath and FIFO bookkeeping
  always_comb begin
    state_nxt   = state;
    lba_nxt     = sd_lba;
    rem_nxt     = remaining;
    busy_nxt    = busy;
    err_nxt     = err;
    byte_nxt    = byte_cnt;
    lo_nxt      = lo_byte;
    tmo_nxt     = tmo;
    wr_nxt      = wr_ptr;
    rd_nxt      = rd_ptr;
    cnt_nxt     = fifo_cnt;
    sec_nxt     = sectors_ready;
    pop_cnt_nxt = pop_cnt;
    push        = 1'b0;
    flush       = 1'b0;
    go_err      = 1'b0;
    sec_done    = 1'b0;
    sec_popped  = 1'b0;
    intrq_set   = 1'b0;
    intrq_clr   = 1'b0;
    pop         = host_rd && host_drq;

    case (state)
      S_IDLE, S_ERROR: begin
        if (cmd_valid) begin
          lba_nxt   = cmd_lba;
          rem_nxt   = (cmd_count == '0) ? {1'b1, {CNT_W{1'b0}}} : REM_W'(cmd_count);
          flush     = 1'b1;
          err_nxt   = 1'b0;
          intrq_clr = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = S_SPACE;
        end
      end
      S_SPACE: begin
        // Only start a read when a whole sector fits, so the FIFO cannot overflow
        if (fifo_cnt <= CW'(FIFO_WORDS - SECTOR_WORDS)) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        byte_nxt  = '0;
        tmo_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        tmo_nxt = tmo + TMO_W'(1);
        // Count saturates one past a sector so an over-long sector fails on sd_done
        if (sd_data_valid && byte_cnt <= BC_W'(SECTOR_BYTES)) begin
          byte_nxt = byte_cnt + BC_W'(1);
          if (byte_cnt < BC_W'(SECTOR_BYTES)) begin
            if (byte_cnt[0]) push = 1'b1;
            else             lo_nxt = sd_data;
          end
        end
        if (sd_error || (sd_done && byte_cnt != BC_W'(SECTOR_BYTES))) begin
          go_err = 1'b1;
        end else if (sd_done) begin
          sec_done  = 1'b1;
          intrq_set = 1'b1;
          lba_nxt   = sd_lba + LBA_W'(1);
          rem_nxt   = remaining - REM_W'(1);
          state_nxt = (remaining == REM_W'(1)) ? S_DRAIN : S_SPACE;
        end else if (tmo == TMO_W'(TIMEOUT_CYC - 2)) begin
          // ERROR becomes visible exactly TIMEOUT_CYC cycles after the start pulse
          go_err = 1'b1;
        end
      end
      S_DRAIN: begin
        if (sectors_ready == '0 && fifo_cnt == '0) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (go_err) begin
      state_nxt = S_ERROR;
      err_nxt   = 1'b1;
      busy_nxt  = 1'b0;
      flush     = 1'b1;
      intrq_set = 1'b1;
    end

    if (pop) intrq_clr = 1'b1;

    if (flush) begin
      wr_nxt      = '0;
      rd_nxt      = '0;
      cnt_nxt     = '0;
      sec_nxt     = '0;
      pop_cnt_nxt = '0;
    end else begin
      if (push) wr_nxt = wr_ptr + AW'(1);
      if (pop) begin
        rd_nxt = rd_ptr + AW'(1);
        if (pop_cnt == PC_W'(SECTOR_WORDS - 1)) begin
          pop_cnt_nxt = '0;
          sec_popped  = 1'b1;
        end else begin
          pop_cnt_nxt = pop_cnt + PC_W'(1);
        end
      end
      cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
      sec_nxt = sectors_ready + CW'(sec_done) - CW'(sec_popped);
    end

    mem_we    = push && !flush;
    intrq_nxt = intrq_set ? 1'b1 : (intrq_clr ? 1'b0 : intrq);
    drq_nxt   = (sec_nxt != '0);
    start_nxt = (state_nxt == S_ISSUE);
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sd_lba        <= '0;
      remaining     <= '0;
      busy          <= 1'b0;
      cmd_ready     <= 1'b1;
      err           <= 1'b0;
      intrq         <= 1'b0;
      host_drq      <= 1'b0;
      sd_start_read <= 1'b0;
      byte_cnt      <= '0;
      lo_byte       <= '0;
      tmo           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      sectors_ready <= '0;
      pop_cnt       <= '0;
    end else begin
      state         <= state_nxt;
      sd_lba        <= lba_nxt;
      remaining     <= rem_nxt;
      busy          <= busy_nxt;
      cmd_ready     <= ~busy_nxt;
      err           <= err_nxt;
      intrq         <= intrq_nxt;
      host_drq      <= drq_nxt;
      sd_start_read <= start_nxt;
      byte_cnt      <= byte_nxt;
      lo_byte       <= lo_nxt;
      tmo           <= tmo_nxt;
      wr_ptr        <= wr_nxt;
      rd_ptr        <= rd_nxt;
      fifo_cnt      <= cnt_nxt;
      sectors_ready <= sec_nxt;
      pop_cnt       <= pop_cnt_nxt;
    end
  end

  // Word storage; little-endian packing (first byte in [7:0])
  always_ff @(posedge clk) begin
    if (mem_we) fifo_mem[wr_ptr] <= {sd_data, lo_byte};
  end

  // First-word-fall-through head; reads as zero while the FIFO is empty
  assign host_data   = (fifo_cnt == '0) ? 16'h0000 : fifo_mem[rd_ptr];
  assign status_leds = LED_W'({err, intrq, host_drq, state});

endmodule

// File: tb/tb_ide_sd_sector_bridge.sv
// Self-checking bench for ide_sd_sector_bridge: randomised SD byte timing and
// host pops against a queue-based model of the expected word stream and LBAs.
module tb_ide_sd_sector_bridge;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned FIFO_WORDS   = 512;
  localparam int unsigned LBA_W        = 32;
  localparam int unsigned CNT_W        = 2;
  localparam int unsigned TIMEOUT_CYC  = 1000;
  localparam int unsigned LED_W        = 8;

  localparam int MODE_OK     = 0;
  localparam int MODE_SHORT  = 1;
  localparam int MODE_ERRMID = 2;
  localparam int MODE_SILENT = 3;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LBA_W-1:0] cmd_lba;
  logic [CNT_W-1:0] cmd_count;
  logic             sd_start_read;
  logic [LBA_W-1:0] sd_lba;
  logic [7:0]       sd_data;
  logic             sd_data_valid;
  logic             sd_done;
  logic             sd_error;
  logic             host_rd;
  logic [15:0]      host_data;
  logic             host_drq;
  logic             intrq;
  logic             busy;
  logic             err;
  logic [LED_W-1:0] status_leds;

  ide_sd_sector_bridge #(
    .SECTOR_BYTES(SECTOR_BYTES),
    .FIFO_WORDS  (FIFO_WORDS),
    .LBA_W       (LBA_W),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LED_W       (LED_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_lba      (cmd_lba),
    .cmd_count    (cmd_count),
    .sd_start_read(sd_start_read),
    .sd_lba       (sd_lba),
    .sd_data      (sd_data),
    .sd_data_valid(sd_data_valid),
    .sd_done      (sd_done),
    .sd_error     (sd_error),
    .host_rd      (host_rd),
    .host_data    (host_data),
    .host_drq     (host_drq),
    .intrq        (intrq),
    .busy         (busy),
    .err          (err),
    .status_leds  (status_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          cyc;
  int          issues;
  logic [31:0] exp_lba;
  logic [15:0] exp_q[$];
  int          rphase;
  int          bidx;
  logic [7:0]  lo_b;
  int          sd_mode;
  int          err_issue;
  bit          host_en;
  bit          spam_cmd;
  bit          seq_bytes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample after the edge, then drive SD responder, host and inputs
  task automatic tick();
    logic [7:0] b;
    int         nbytes;
    @(posedge clk);
    #1;
    cyc++;
    cmd_valid     = 1'b0;
    sd_data_valid = 1'b0;
    sd_done       = 1'b0;
    sd_error      = 1'b0;
    host_rd       = 1'b0;
    nbytes = (sd_mode == MODE_SHORT) ? int'(SECTOR_BYTES) - 1 : int'(SECTOR_BYTES);

    if (sd_start_read) begin
      issues++;
      check("sd_lba", sd_lba, exp_lba);
      exp_lba = exp_lba + 32'd1;
      rphase  = 1;
      bidx    = 0;
    end else if (rphase == 1) begin
      if (sd_mode == MODE_ERRMID && issues == err_issue && bidx == 100) begin
        sd_error = 1'b1;
        rphase   = 0;
        exp_q.delete();
      end else if (bidx == nbytes) begin
        sd_done = 1'b1;
        rphase  = 0;
        if (sd_mode == MODE_SHORT) exp_q.delete();
      end else if (!(sd_mode == MODE_SILENT && bidx >= 10) && $urandom_range(3) != 0) begin
        b = seq_bytes ? 8'(bidx) : 8'($urandom);
        sd_data       = b;
        sd_data_valid = 1'b1;
        if (bidx % 2 == 0) lo_b = b;
        else exp_q.push_back({b, lo_b});
        bidx++;
      end
    end

    if (host_en && host_drq && $urandom_range(9) < 7) begin
      if (exp_q.size() == 0) begin
        check("pop_vs_model", 32'(exp_q.size()), 32'd1);
      end else begin
        check("host_data", 32'(host_data), 32'(exp_q.pop_front()));
      end
      host_rd = 1'b1;
    end

    if (spam_cmd && busy && $urandom_range(29) == 0) begin
      cmd_valid = 1'b1;
      cmd_lba   = $urandom;
      cmd_count = CNT_W'($urandom);
    end
  endtask

  task automatic issue_cmd(input logic [31:0] lba, input logic [CNT_W-1:0] cnt);
    exp_lba   = lba;
    issues    = 0;
    rphase    = 0;
    cmd_valid = 1'b1;
    cmd_lba   = lba;
    cmd_count = cnt;
  endtask

  task automatic wait_not_busy(input int bound, input string tag);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] st, input int bound, input string tag);
    int n;
    n = 0;
    while (status_leds[2:0] != st && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(status_leds[2:0]), 32'(st));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_intrq"}, 32'(intrq), 32'd0);
    check({tag, "_drq"}, 32'(host_drq), 32'd0);
    check({tag, "_start"}, 32'(sd_start_read), 32'd0);
    check({tag, "_sd_lba"}, sd_lba, 32'd0);
    check({tag, "_host_data"}, 32'(host_data), 32'd0);
    check({tag, "_leds"}, 32'(status_leds), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    checks = 0; errors = 0; cyc = 0; issues = 0; exp_lba = '0;
    rphase = 0; bidx = 0; lo_b = '0; sd_mode = MODE_OK; err_issue = 0;
    host_en = 1'b0; spam_cmd = 1'b0; seq_bytes = 1'b0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_lba = '0; cmd_count = '0;
    sd_data = '0; sd_data_valid = 1'b0; sd_done = 1'b0; sd_error = 1'b0; host_rd = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;
    tick();

    // 1 sector, LBA 0x10, sequential bytes
    seq_bytes = 1'b1;
    host_en   = 1'b1;
    issue_cmd(32'h10, 2'd1);
    tick();
    check("lat_n1", 32'(issues), 32'd0);
    check("cmd_ready_low", 32'(cmd_ready), 32'd0);
    check("busy_set", 32'(busy), 32'd1);
    tick();
    check("lat_n2", 32'(issues), 32'd1);
    check("start_pulse", 32'(sd_start_read), 32'd1);
    tick();
    check("start_once", 32'(sd_start_read), 32'd0);
    wait_not_busy(4000, "t1_busy_fall");
    check("t1_issues", 32'(issues), 32'd1);
    check("t1_all_popped", 32'(exp_q.size()), 32'd0);
    check("t1_intrq", 32'(intrq), 32'd0);
    seq_bytes = 1'b0;

    // 3 sectors from LBA 0xFFFFFFFF with the host idle: third read waits for space
    host_en = 1'b0;
    issue_cmd(32'hFFFF_FFFF, 2'd3);
    n = 0;
    tick();
    while (!(issues == 2 && rphase == 0) && n < 4000) begin
      tick();
      n++;
    end
    repeat (100) tick();
    check("t2_issues_held", 32'(issues), 32'd2);
    check("t2_space_st", 32'(status_leds[2:0]), 32'd3);
    check("t2_drq", 32'(host_drq), 32'd1);
    check("t2_intrq", 32'(intrq), 32'd1);
    host_en = 1'b1;
    wait_not_busy(8000, "t2_busy_fall");
    check("t2_issues", 32'(issues), 32'd3);
    check("t2_err", 32'(err), 32'd0);

    // count 0 means 4 sectors; stray commands while busy are ignored
    issue_cmd($urandom, 2'd0);
    spam_cmd = 1'b1;
    tick();
    wait_not_busy(12000, "t3_busy_fall");
    spam_cmd = 1'b0;
    check("t3_issues", 32'(issues), 32'd4);
    check("t3_cmd_ready", 32'(cmd_ready), 32'd1);

    // timeout: SD goes silent after a few bytes
    sd_mode = MODE_SILENT;
    host_en = 1'b0;
    issue_cmd($urandom, 2'd1);
    n = 0;
    while (issues == 0 && n < 20) begin
      tick();
      n++;
    end
    check("to_issued", 32'(issues), 32'd1);
    t0 = cyc;
    while (cyc < t0 + int'(TIMEOUT_CYC) - 1) tick();
    check("to_wait_st", 32'(status_leds[2:0]), 32'd2);
    tick();
    exp_q.delete();
    rphase  = 0;
    sd_mode = MODE_OK;
    check("to_err_st", 32'(status_leds[2:0]), 32'd5);
    check("to_err", 32'(err), 32'd1);
    check("to_intrq", 32'(intrq), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_cmd_ready", 32'(cmd_ready), 32'd1);
    check("to_drq", 32'(host_drq), 32'd0);
    host_rd = 1'b1;
    tick();
    check("rd_nodrq_leds", 32'(status_leds), 32'h35);
    host_en = 1'b1;
    issue_cmd($urandom, 2'd1);
    tick();
    check("newcmd_err", 32'(err), 32'd0);
    check("newcmd_intrq", 32'(intrq), 32'd0);
    check("newcmd_busy", 32'(busy), 32'd1);
    wait_not_busy(4000, "newcmd_busy_fall");
    check("newcmd_issues", 32'(issues), 32'd1);

    // sd_done after 511 bytes
    sd_mode = MODE_SHORT;
    issue_cmd($urandom, 2'd1);
    tick();
    wait_state(3'd5, 3000, "short_err_st");
    check("short_err", 32'(err), 32'd1);
    sd_mode = MODE_OK;

    // sd_error mid-sector with a complete sector still queued
    sd_mode   = MODE_ERRMID;
    err_issue = 2;
    host_en   = 1'b0;
    issue_cmd($urandom, 2'd2);
    n = 0;
    tick();
    while (issues < 2 && n < 4000) begin
      tick();
      n++;
    end
    check("em_drq_before", 32'(host_drq), 32'd1);
    wait_state(3'd5, 3000, "em_err_st");
    check("em_drq_after", 32'(host_drq), 32'd0);
    check("em_err", 32'(err), 32'd1);
    check("em_intrq", 32'(intrq), 32'd1);
    sd_mode = MODE_OK;
    host_en = 1'b1;
    issue_cmd($urandom, 2'd1);
    tick();
    wait_not_busy(4000, "em_next_busy_fall");
    check("em_next_issues", 32'(issues), 32'd1);

    // asynchronous reset in the middle of a sector
    host_en = 1'b0;
    issue_cmd($urandom, 2'd2);
    n = 0;
    tick();
    while (!(issues == 1 && bidx >= 100) && n < 2000) begin
      tick();
      n++;
    end
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    rphase = 0;
    exp_q.delete();
    sd_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (50) tick();
    check("rst_no_start", 32'(issues), 32'd1);
    check("rst_idle_st", 32'(status_leds[2:0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
